mmio_timer: RTL and testbench

Memory-mapped machine timer on the responder (MEM) side of the MMIO bus. It owns the 64-bit `mtime` counter and the `mtimecmp` compare register. It serves loads and stores issued by the core's MMIO host, and drives both registers to the CSR unit through the MMIO side of the CSR/MMIO timer interface. A registered timer-interrupt level is also provided for the trap logic.

---
 rtl/mmio_timer_pkg.sv | 30 +++
 rtl/mmio_timer_if.sv | 26 ++
 rtl/mmio_timer_tick_gen.sv | 21 ++
 rtl/mmio_timer.sv | 89 ++++++++
 tb/tb_mmio_timer.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/mmio_timer_pkg.sv
// Shared constants, register selectors and byte-merge helper for the MMIO machine timer.
package mmio_timer_pkg;

    localparam logic [31:0] MMIO_TIMER_BASE = 32'hFF00_0080;

    localparam logic [3:0] MMIO_TIMER_MTIME_LO    = 4'h0;
    localparam logic [3:0] MMIO_TIMER_MTIME_HI    = 4'h4;
    localparam logic [3:0] MMIO_TIMER_MTIMECMP_LO = 4'h8;
    localparam logic [3:0] MMIO_TIMER_MTIMECMP_HI = 4'hC;

    // Word selector is addr[3:2]; encodings follow the offsets above.
    typedef enum logic [1:0] {
        REG_MTIME_LO    = 2'd0,
        REG_MTIME_HI    = 2'd1,
        REG_MTIMECMP_LO = 2'd2,
        REG_MTIMECMP_HI = 2'd3
    } reg_sel_e;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  mask);
        logic [31:0] r;
        r = old_w;
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) r[8*i +: 8] = new_w[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/mmio_timer_if.sv
// MMIO load/store bus and the CSR-facing timer register view.
interface IF_MMIO;
    logic        we;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic        re;
    logic [31:0] raddr;
    logic [1:0]  rsize;
    logic [31:0] rdata;
    logic        rbusy;
    logic        wbusy;

    modport MEM  (input  we, waddr, wdata, wmask, re, raddr, rsize,
                  output rdata, rbusy, wbusy);
    modport HOST (output we, waddr, wdata, wmask, re, raddr, rsize,
                  input  rdata, rbusy, wbusy);
endinterface

interface IF_CSR_MMIO;
    logic [63:0] mtime;
    logic [63:0] mtimecmp;

    modport MMIO (output mtime, mtimecmp);
    modport CSR  (input  mtime, mtimecmp);
endinterface

// File: rtl/mmio_timer_tick_gen.sv
// Prescaler: single-cycle tick every DIV clocks (DIV = 1 ticks every cycle).
module tick_gen #(
    parameter int unsigned DIV = 1
) (
    input  logic clk_i,
    input  logic rst_ni,
    output logic tick_o
);
    localparam logic [15:0] LAST = 16'(DIV - 1);

    logic [15:0] cnt_q, cnt_d;

    assign tick_o = (cnt_q == LAST);
    assign cnt_d  = tick_o ? 16'd0 : cnt_q + 16'd1;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) cnt_q <= 16'd0;
        else         cnt_q <= cnt_d;
    end

endmodule

// File: rtl/mmio_timer.sv
// Memory-mapped mtime/mtimecmp with byte-masked stores, sized loads and a registered timer IRQ.
module mmio_timer
    import mmio_timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = MMIO_TIMER_BASE,
    parameter int unsigned TICK_DIV  = 1
) (
    input  logic     clk,
    input  logic     rst,
    IF_MMIO.MEM      mmio,
    IF_CSR_MMIO.MMIO csrIF,
    output logic     OUT_timerIRQ
);
    logic        tick;
    logic [63:0] mtime_q, mtime_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic [31:0] rdata_q, rdata_d;
    logic        irq_q, rbusy_q, wbusy_q;
    logic        w_acc, r_acc;
    reg_sel_e    w_sel, r_sel;
    logic [31:0] r_word, r_shift;

    tick_gen #(.DIV(TICK_DIV)) u_tick_gen (
        .clk_i  (clk),
        .rst_ni (rst),
        .tick_o (tick)
    );

    always_comb begin
        w_acc = mmio.we && !wbusy_q && (mmio.waddr[31:4] == BASE_ADDR[31:4]);
        r_acc = mmio.re && !rbusy_q && (mmio.raddr[31:4] == BASE_ADDR[31:4]);
        w_sel = reg_sel_e'(mmio.waddr[3:2]);
        r_sel = reg_sel_e'(mmio.raddr[3:2]);

        // A store to either mtime half replaces the whole increment for that cycle.
        mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
        mtimecmp_d = mtimecmp_q;
        if (w_acc) begin
            case (w_sel)
                REG_MTIME_LO:    mtime_d    = {mtime_q[63:32], merge_bytes(mtime_q[31:0], mmio.wdata, mmio.wmask)};
                REG_MTIME_HI:    mtime_d    = {merge_bytes(mtime_q[63:32], mmio.wdata, mmio.wmask), mtime_q[31:0]};
                REG_MTIMECMP_LO: mtimecmp_d = {mtimecmp_q[63:32], merge_bytes(mtimecmp_q[31:0], mmio.wdata, mmio.wmask)};
                REG_MTIMECMP_HI: mtimecmp_d = {merge_bytes(mtimecmp_q[63:32], mmio.wdata, mmio.wmask), mtimecmp_q[31:0]};
                default:         mtimecmp_d = mtimecmp_q;
            endcase
        end

        r_word = mtime_q[31:0];
        case (r_sel)
            REG_MTIME_LO:    r_word = mtime_q[31:0];
            REG_MTIME_HI:    r_word = mtime_q[63:32];
            REG_MTIMECMP_LO: r_word = mtimecmp_q[31:0];
            REG_MTIMECMP_HI: r_word = mtimecmp_q[63:32];
            default:         r_word = mtime_q[31:0];
        endcase
        r_shift = r_word >> {mmio.raddr[1:0], 3'b000};
        case (mmio.rsize)
            2'd0:    rdata_d = {24'd0, r_shift[7:0]};
            2'd1:    rdata_d = {16'd0, r_shift[15:0]};
            default: rdata_d = r_shift;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            mtime_q    <= 64'd0;
            mtimecmp_q <= {64{1'b1}};
            rdata_q    <= 32'd0;
            irq_q      <= 1'b0;
            rbusy_q    <= 1'b1;
            wbusy_q    <= 1'b1;
        end else begin
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            if (r_acc) rdata_q <= rdata_d;
            irq_q      <= (mtime_q >= mtimecmp_q);
            rbusy_q    <= 1'b0;
            wbusy_q    <= 1'b0;
        end
    end

    assign mmio.rdata     = rdata_q;
    assign mmio.rbusy     = rbusy_q;
    assign mmio.wbusy     = wbusy_q;
    assign csrIF.mtime    = mtime_q;
    assign csrIF.mtimecmp = mtimecmp_q;
    assign OUT_timerIRQ   = irq_q;

endmodule

// File: tb/tb_mmio_timer.sv
// Bench for mmio_timer: reference model of the register file plus a read scoreboard.
module tb_mmio_timer;
    import mmio_timer_pkg::*;

    localparam logic [31:0] BASE = MMIO_TIMER_BASE;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    IF_MMIO     m1();
    IF_CSR_MMIO c1();
    logic       irq1;
    IF_MMIO     m4();
    IF_CSR_MMIO c4();
    logic       irq4;

    mmio_timer #(.BASE_ADDR(BASE), .TICK_DIV(1)) dut1 (
        .clk(clk), .rst(rst), .mmio(m1), .csrIF(c1), .OUT_timerIRQ(irq1));
    mmio_timer #(.BASE_ADDR(BASE), .TICK_DIV(4)) dut4 (
        .clk(clk), .rst(rst), .mmio(m4), .csrIF(c4), .OUT_timerIRQ(irq4));

    int checks = 0;
    int errors = 0;

    logic [63:0] m_time, m_cmp;
    logic        m_irq;
    bit          m_busy;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Reference model for the TICK_DIV=1 instance, updated on every rising edge.
    always @(posedge clk) begin : model
        logic [63:0] ot, oc;
        logic [31:0] w;
        ot = m_time;
        oc = m_cmp;
        if (!rst) begin
            m_time = 64'd0;
            m_cmp  = {64{1'b1}};
            m_irq  = 1'b0;
            m_busy = 1'b1;
            exp_q.delete();
        end else begin
            m_irq  = (ot >= oc);
            m_time = ot + 64'd1;
            if (m1.re && !m_busy && m1.raddr[31:4] == BASE[31:4]) begin
                case (m1.raddr[3:2])
                    2'd0:    w = ot[31:0];
                    2'd1:    w = ot[63:32];
                    2'd2:    w = oc[31:0];
                    default: w = oc[63:32];
                endcase
                w = w >> (8 * m1.raddr[1:0]);
                if (m1.rsize == 2'd0)      w = w & 32'h0000_00FF;
                else if (m1.rsize == 2'd1) w = w & 32'h0000_FFFF;
                exp_q.push_back(w);
            end
            if (m1.we && !m_busy && m1.waddr[31:4] == BASE[31:4]) begin
                case (m1.waddr[3:2])
                    2'd0:    w = ot[31:0];
                    2'd1:    w = ot[63:32];
                    2'd2:    w = oc[31:0];
                    default: w = oc[63:32];
                endcase
                for (int i = 0; i < 4; i++)
                    if (m1.wmask[i]) w[8*i +: 8] = m1.wdata[8*i +: 8];
                case (m1.waddr[3:2])
                    2'd0:    m_time = {ot[63:32], w};
                    2'd1:    m_time = {w, ot[31:0]};
                    2'd2:    m_cmp  = {oc[63:32], w};
                    default: m_cmp  = {w, oc[31:0]};
                endcase
            end
            m_busy = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        while (exp_q.size() > 0) check("rdata_sb", m1.rdata, exp_q.pop_front());
        check("mtime_model", c1.mtime, m_time);
        check("mtimecmp_model", c1.mtimecmp, m_cmp);
        check("irq_model", irq1, m_irq);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] mk);
        m1.we = 1'b1; m1.waddr = a; m1.wdata = d; m1.wmask = mk;
        step();
        m1.we = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [1:0] sz);
        m1.re = 1'b1; m1.raddr = a; m1.rsize = sz;
        step();
        m1.re = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit found;
        m1.we = 0; m1.waddr = 0; m1.wdata = 0; m1.wmask = 0; m1.re = 0; m1.raddr = 0; m1.rsize = 0;
        m4.we = 0; m4.waddr = 0; m4.wdata = 0; m4.wmask = 0; m4.re = 0; m4.raddr = 0; m4.rsize = 0;

        repeat (3) @(negedge clk);
        check("rst_rbusy", m1.rbusy, 1);
        check("rst_wbusy", m1.wbusy, 1);
        check("rst_mtime", c1.mtime, 64'd0);
        check("rst_mtimecmp", c1.mtimecmp, 64'hFFFF_FFFF_FFFF_FFFF);
        check("rst_irq", irq1, 0);
        check("rst_rdata", m1.rdata, 32'd0);
        check("rst_busy4", {m4.rbusy, m4.wbusy}, 2'b11);

        // Release reset; slow instance counts once per four cycles.
        rst = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (k == 1) begin
                check("rel_rbusy", m1.rbusy, 0);
                check("rel_wbusy", m1.wbusy, 0);
                check("rel_busy4", {m4.rbusy, m4.wbusy}, 2'b00);
            end
            if (k == 4)  check("div4_mtime_4", c4.mtime, 64'd1);
            if (k == 20) check("div4_mtime_20", c4.mtime, 64'd5);
            check("div4_irq", irq4, 0);
        end

        // Low-half overflow carries on tick but not on write.
        wr(BASE + 32'h0, 32'hFFFF_FFFF, 4'hF);
        wr(BASE + 32'h4, 32'h0, 4'hF);
        check("lo_write_nocarry", c1.mtime, 64'h0000_0000_FFFF_FFFF);
        step();
        check("carry_tick", c1.mtime, 64'h0000_0001_0000_0000);
        rd(BASE + 32'h4, 2'd2);
        check("rd_hi", m1.rdata, 32'd1);

        // Full 64-bit wrap.
        wr(BASE + 32'h0, 32'hFFFF_FFFF, 4'hF);
        wr(BASE + 32'h4, 32'hFFFF_FFFF, 4'hF);
        check("all_ones", c1.mtime, 64'hFFFF_FFFF_FFFF_FFFF);
        step();
        check("wrap_zero", c1.mtime, 64'd0);

        // Compare at 10 with mtime counting from 0.
        wr(BASE + 32'h4, 32'h0, 4'hF);
        wr(BASE + 32'h0, 32'h0, 4'hF);
        wr(BASE + 32'hC, 32'h0, 4'hF);
        wr(BASE + 32'h8, 32'd10, 4'hF);
        found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            if (c1.mtime == 64'd10) begin
                check("irq_at_10", irq1, 0);
                step();
                check("irq_rise", irq1, 1);
                found = 1;
            end else begin
                step();
            end
        end
        check("irq_found", found, 1);

        // Single-byte store into mtimecmp lane 2.
        wr(BASE + 32'h8, 32'h00AB_0000, 4'b0100);
        check("byte_store", c1.mtimecmp, 64'h0000_0000_00AB_000A);
        rd(BASE + 32'hA, 2'd0);
        check("rd_byte", m1.rdata, 32'h0000_00AB);

        // Halfword load at offset 2, then out-of-window accesses.
        wr(BASE + 32'h0, 32'h1234_5678, 4'hF);
        rd(BASE + 32'h2, 2'd1);
        check("rd_half", m1.rdata, 32'h0000_1234);
        rd(32'h0000_0000, 2'd2);
        check("oow_rd_hold", m1.rdata, 32'h0000_1234);
        rd(BASE + 32'h10, 2'd2);
        check("oow_rd_hold2", m1.rdata, 32'h0000_1234);
        wr(BASE + 32'h18, 32'h0, 4'hF);
        check("oow_wr_cmp", c1.mtimecmp, 64'h0000_0000_00AB_000A);

        // Write during a tick wins over the increment.
        wr(BASE + 32'h0, 32'd7, 4'hF);
        wr(BASE + 32'h0, 32'd100, 4'hF);
        check("tick_write", c1.mtime, 64'd100);

        // Same-word read and write: old value returned, write commits.
        m1.re = 1'b1; m1.raddr = BASE + 32'h8; m1.rsize = 2'd2;
        m1.we = 1'b1; m1.waddr = BASE + 32'h8; m1.wdata = 32'h5555_5555; m1.wmask = 4'hF;
        step();
        m1.re = 1'b0; m1.we = 1'b0;
        check("rw_old", m1.rdata, 32'h00AB_000A);
        check("rw_commit", c1.mtimecmp, 64'h0000_0000_5555_5555);

        // Reset asserted together with a read.
        m1.re = 1'b1; m1.raddr = BASE + 32'h0; m1.rsize = 2'd2;
        rst = 1'b0;
        step();
        m1.re = 1'b0;
        check("rst_mid_rdata", m1.rdata, 32'd0);
        check("rst_mid_mtime", c1.mtime, 64'd0);
        check("rst_mid_rbusy", m1.rbusy, 1);
        rst = 1'b1;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
